// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Bundles the signals between the shared-ALU arbiter, its two requesters
// (EXE stage = requester 0, address/loop helper = requester 1) and the ALU.
//   req*       : request handshake, operands, command, status-update flag
//   alu_*      : operands/command/carry-in to the ALU and its result/flags
//   rsp*       : per-requester response handshake, shared result/flags
//   status_reg : architectural NZCV owned by the arbiter
// Modports: slave = arbiter side, master = requesters/ALU side.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]        req0_exe_cmd, req1_exe_cmd;
  logic              req0_s, req1_s;

  logic [DATA_W-1:0] alu_in1, alu_in2;
  logic [3:0]        alu_exe_cmd;
  logic              alu_cin;
  logic [DATA_W-1:0] alu_out;
  logic              alu_n, alu_z, alu_c, alu_v;

  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        rsp_nzcv;
  logic [3:0]        status_reg;

  modport slave (
    input  req0_valid, req1_valid, req0_in1, req0_in2, req1_in1, req1_in2,
           req0_exe_cmd, req1_exe_cmd, req0_s, req1_s,
           alu_out, alu_n, alu_z, alu_c, alu_v, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, alu_in1, alu_in2, alu_exe_cmd, alu_cin,
           rsp0_valid, rsp1_valid, rsp_data, rsp_nzcv, status_reg
  );

  modport master (
    output req0_valid, req1_valid, req0_in1, req0_in2, req1_in1, req1_in2,
           req0_exe_cmd, req1_exe_cmd, req0_s, req1_s,
           alu_out, alu_n, alu_z, alu_c, alu_v, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, alu_in1, alu_in2, alu_exe_cmd, alu_cin,
           rsp0_valid, rsp1_valid, rsp_data, rsp_nzcv, status_reg
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares the single execute-stage ALU between two requesters. Requests are
// arbitrated round-robin in IDLE, the granted operands drive the ALU for one
// EXEC cycle, and the captured result/flags are returned in RESP through the
// owner's response handshake. Also owns the architectural NZCV register,
// whose C bit feeds the ALU carry-in.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : alu_share_arbiter_if.slave (requests, ALU, responses, status_reg)
module alu_share_arbiter #(
  parameter bit PRIO_INIT = 1'b0,
  parameter int DATA_W    = 32
) (
  input logic                clk,
  input logic                rst,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              grant0, grant1;
  logic              last_grant_q;
  logic              owner_q;
  logic [DATA_W-1:0] in1_q, in2_q;
  logic [3:0]        cmd_q;
  logic              s_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [3:0]        rsp_nzcv_q;
  logic [3:0]        status_q;

  // Arithmetic ops write all flags, move/logic ops only N and Z.
  function automatic logic [3:0] status_upd(input logic [3:0] cur,
                                            input logic [3:0] nzcv,
                                            input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b0011, 4'b0100, 4'b0101:          return nzcv;
      4'b0001, 4'b1001, 4'b0110, 4'b0111, 4'b1000: return {nzcv[3:2], cur[1:0]};
      default:                                     return cur;
    endcase
  endfunction

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant0 || grant1) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
    bus.rsp0_valid = (state_q == RESP) && !owner_q;
    bus.rsp1_valid = (state_q == RESP) &&  owner_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= ~PRIO_INIT;
      owner_q      <= 1'b0;
      in1_q        <= '0;
      in2_q        <= '0;
      cmd_q        <= 4'b0;
      s_q          <= 1'b0;
      rsp_data_q   <= '0;
      rsp_nzcv_q   <= 4'b0;
      status_q     <= 4'b0;
    end else begin
      if (grant0 || grant1) begin
        owner_q      <= grant1;
        last_grant_q <= grant1;
        in1_q        <= grant1 ? bus.req1_in1     : bus.req0_in1;
        in2_q        <= grant1 ? bus.req1_in2     : bus.req0_in2;
        cmd_q        <= grant1 ? bus.req1_exe_cmd : bus.req0_exe_cmd;
        s_q          <= grant1 ? bus.req1_s       : bus.req0_s;
      end
      if (state_q == EXEC) begin
        rsp_data_q <= bus.alu_out;
        rsp_nzcv_q <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
        if (s_q)
          status_q <= status_upd(status_q,
                                 {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v},
                                 cmd_q);
      end
    end
  end

  assign bus.alu_in1     = in1_q;
  assign bus.alu_in2     = in2_q;
  assign bus.alu_exe_cmd = cmd_q;
  assign bus.alu_cin     = status_q[1];
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_nzcv    = rsp_nzcv_q;
  assign bus.status_reg  = status_q;

endmodule
